// File: rtl/led_step_ctrl.sv
// rtl/led_step_ctrl.sv - debounced speed/mode buttons driving step strobe and direction for the LED shifter
module led_step_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int BASE_PERIOD = 25000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_speed_n,
    input  logic       key_mode_n,
    output logic       step,
    output logic       dir,
    output logic       run,
    output logic [1:0] speed
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam int CW = $clog2(8 * BASE_PERIOD);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [CW:0]   BASE     = (CW+1)'(BASE_PERIOD);
    localparam logic [CW:0]   ONE      = (CW+1)'(1);

    typedef enum logic [1:0] {
        RUN_L = 2'd0,
        RUN_R = 2'd1,
        PAUSE = 2'd2
    } mode_e;

    // Index 0 is the speed key, index 1 the mode key.
    logic [1:0]         sync1_q, sync2_q;
    logic [1:0]         deb_q, deb_d;
    logic [1:0]         deb_dly_q;
    logic [1:0][DW-1:0] deb_cnt_q, deb_cnt_d;
    logic [1:0]         press;

    mode_e         state_q, state_d;
    logic [1:0]    speed_q, speed_d;
    logic [CW-1:0] step_cnt_q, step_cnt_d;
    logic          step_q, step_d;
    logic          dir_q, dir_d;
    logic          run_q, run_d;
    logic [CW:0]   period_m1;

    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == deb_q[i]) begin
                deb_cnt_d[i] = '0;
            end else if (deb_cnt_q[i] == DEB_LAST) begin
                deb_d[i]     = sync2_q[i];
                deb_cnt_d[i] = '0;
            end else begin
                deb_cnt_d[i] = deb_cnt_q[i] + DW'(1);
            end
        end
    end

    // Press is a falling edge of the debounced level; releases are ignored.
    assign press     = deb_dly_q & ~deb_q;
    assign period_m1 = (BASE << (2'd3 - speed_q)) - ONE;

    always_comb begin
        state_d = state_q;
        if (press[1]) begin
            case (state_q)
                RUN_L:   state_d = RUN_R;
                RUN_R:   state_d = PAUSE;
                PAUSE:   state_d = RUN_L;
                default: state_d = RUN_L;
            endcase
        end

        speed_d = speed_q;
        if (press[0]) begin
            speed_d = speed_q + 2'd1;
        end

        step_d     = 1'b0;
        step_cnt_d = step_cnt_q;
        if (run_q) begin
            if ({1'b0, step_cnt_q} == period_m1) begin
                step_d     = 1'b1;
                step_cnt_d = '0;
            end else begin
                step_cnt_d = step_cnt_q + CW'(1);
            end
        end
        if (press[0]) begin
            step_cnt_d = '0;
        end

        // PAUSE is only entered from RUN_R, so dir stays 1 there.
        dir_d = (state_d != RUN_L);
        run_d = (state_d != PAUSE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            deb_q      <= 2'b11;
            deb_dly_q  <= 2'b11;
            deb_cnt_q  <= '0;
            state_q    <= RUN_L;
            speed_q    <= 2'd0;
            step_cnt_q <= '0;
            step_q     <= 1'b0;
            dir_q      <= 1'b0;
            run_q      <= 1'b1;
        end else begin
            sync1_q    <= {key_mode_n, key_speed_n};
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_q;
            deb_cnt_q  <= deb_cnt_d;
            state_q    <= state_d;
            speed_q    <= speed_d;
            step_cnt_q <= step_cnt_d;
            step_q     <= step_d;
            dir_q      <= dir_d;
            run_q      <= run_d;
        end
    end

    assign step  = step_q;
    assign dir   = dir_q;
    assign run   = run_q;
    assign speed = speed_q;

endmodule

// File: tb/tb_led_step_ctrl.sv
// tb/tb_led_step_ctrl.sv - directed self-checking bench for led_step_ctrl
module tb_led_step_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_speed_n = 1'b1;
    logic       key_mode_n = 1'b1;
    logic       step;
    logic       dir;
    logic       run;
    logic [1:0] speed;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_step_ctrl #(
        .DEB_CYCLES (4),
        .BASE_PERIOD(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_speed_n(key_speed_n),
        .key_mode_n (key_mode_n),
        .step       (step),
        .dir        (dir),
        .run        (run),
        .speed      (speed)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycles until the next step pulse, or -1 if none within max.
    task automatic wait_step(input int max, output int n);
        n = -1;
        for (int i = 1; i <= max; i++) begin
            tick;
            if (step) begin
                n = i;
                break;
            end
        end
    endtask

    // Hold the masked keys low for 10 cycles, observe 60 cycles.
    task automatic hold_keys(input logic [1:0] mask, output int k_ev, output int k_step,
                             output logic step_at_ev, output logic [1:0] sp_ev,
                             output logic dir_ev, output logic run_ev);
        logic [3:0] snap;
        snap       = {speed, dir, run};
        k_ev       = 0;
        k_step     = 0;
        step_at_ev = 1'b0;
        sp_ev      = speed;
        dir_ev     = dir;
        run_ev     = run;
        if (mask[0]) key_speed_n = 1'b0;
        if (mask[1]) key_mode_n = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick;
            if (k_ev == 0 && {speed, dir, run} != snap) begin
                k_ev       = k;
                step_at_ev = step;
                sp_ev      = speed;
                dir_ev     = dir;
                run_ev     = run;
            end else if (k_ev != 0 && k_step == 0 && step) begin
                k_step = k;
            end
            if (k == 10) begin
                key_speed_n = 1'b1;
                key_mode_n  = 1'b1;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        tick;
        tick;
        n_checks++;
        if ({step, dir, run, speed} !== 5'b00100) begin
            n_fail++;
            $display("FAIL reset_outputs: got step=%b dir=%b run=%b speed=%0d expected 0 0 1 0", step, dir, run, speed);
        end
        rst = 1'b0;
        wait_step(100, n);
        n_checks++;
        if (n !== 40) begin
            n_fail++;
            $display("FAIL first_step_after_reset: got %0d cycles expected 40", n);
        end
        wait_step(100, n);
        n_checks++;
        if (n !== 40) begin
            n_fail++;
            $display("FAIL idle_period: got %0d cycles expected 40", n);
        end
        for (int i = 0; i < 20; i++) tick;
        n_checks++;
        if ({dir, run, speed} !== 4'b0100) begin
            n_fail++;
            $display("FAIL idle_state: got dir=%b run=%b speed=%0d expected 0 1 0", dir, run, speed);
        end
    endtask

    task automatic test_bounce;
        int k_ev, k_step;
        logic sa, d_e, r_e;
        logic [1:0] sp;
        key_speed_n = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        key_speed_n = 1'b1;
        for (int i = 0; i < 2; i++) tick;
        key_speed_n = 1'b0;
        for (int i = 0; i < 3; i++) tick;
        key_speed_n = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        n_checks++;
        if (speed !== 2'd0) begin
            n_fail++;
            $display("FAIL bounce_rejected: got speed=%0d expected 0", speed);
        end
        hold_keys(2'b01, k_ev, k_step, sa, sp, d_e, r_e);
        n_checks++;
        if (k_ev !== 7 || sp !== 2'd1) begin
            n_fail++;
            $display("FAIL clean_press: got latency=%0d speed=%0d expected 7 1", k_ev, sp);
        end
        n_checks++;
        if (k_step - k_ev !== 20) begin
            n_fail++;
            $display("FAIL restart_period_20: got %0d cycles expected 20", k_step - k_ev);
        end
        n_checks++;
        if (speed !== 2'd1) begin
            n_fail++;
            $display("FAIL single_event_on_hold: got speed=%0d expected 1", speed);
        end
    endtask

    task automatic test_speed_cycle;
        int exp_sp[4]  = '{1, 2, 3, 0};
        int exp_per[4] = '{20, 10, 5, 40};
        int k_ev, k_step, n;
        logic sa, d_e, r_e;
        logic [1:0] sp;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            hold_keys(2'b01, k_ev, k_step, sa, sp, d_e, r_e);
            n_checks++;
            if (k_ev !== 7 || int'(sp) !== exp_sp[i]) begin
                n_fail++;
                $display("FAIL speed_press_%0d: got latency=%0d speed=%0d expected 7 %0d", i, k_ev, sp, exp_sp[i]);
            end
            wait_step(100, n);
            wait_step(100, n);
            n_checks++;
            if (n !== exp_per[i]) begin
                n_fail++;
                $display("FAIL speed_period_%0d: got %0d cycles expected %0d", i, n, exp_per[i]);
            end
        end
    endtask

    task automatic test_mode;
        int k_ev, k_step, n, steps;
        logic sa, d_e, r_e;
        logic [1:0] sp;
        hold_keys(2'b10, k_ev, k_step, sa, sp, d_e, r_e);
        n_checks++;
        if (k_ev !== 7 || d_e !== 1'b1 || r_e !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_run_r: got latency=%0d dir=%b run=%b expected 7 1 1", k_ev, d_e, r_e);
        end
        wait_step(100, n);
        hold_keys(2'b10, k_ev, k_step, sa, sp, d_e, r_e);
        n_checks++;
        if (k_ev !== 7 || d_e !== 1'b1 || r_e !== 1'b0) begin
            n_fail++;
            $display("FAIL mode_pause: got latency=%0d dir=%b run=%b expected 7 1 0", k_ev, d_e, r_e);
        end
        steps = (k_step != 0) ? 1 : 0;
        for (int i = 0; i < 140; i++) begin
            tick;
            if (step) steps++;
        end
        n_checks++;
        if (steps !== 0) begin
            n_fail++;
            $display("FAIL pause_no_step: got %0d steps expected 0", steps);
        end
        hold_keys(2'b10, k_ev, k_step, sa, sp, d_e, r_e);
        n_checks++;
        if (d_e !== 1'b0 || r_e !== 1'b1) begin
            n_fail++;
            $display("FAIL mode_run_l: got dir=%b run=%b expected 0 1", d_e, r_e);
        end
        n_checks++;
        if (k_step - k_ev !== 33) begin
            n_fail++;
            $display("FAIL resume_from_frozen: got %0d cycles expected 33", k_step - k_ev);
        end
    endtask

    task automatic test_simultaneous;
        int k_ev, k_step, n;
        logic sa, d_e, r_e;
        logic [1:0] sp;
        hold_keys(2'b11, k_ev, k_step, sa, sp, d_e, r_e);
        n_checks++;
        if (k_ev !== 7 || sp !== 2'd1 || d_e !== 1'b1 || r_e !== 1'b1) begin
            n_fail++;
            $display("FAIL both_keys: got latency=%0d speed=%0d dir=%b run=%b expected 7 1 1 1", k_ev, sp, d_e, r_e);
        end
        wait_step(100, n);
        for (int i = 0; i < 13; i++) tick;
        hold_keys(2'b01, k_ev, k_step, sa, sp, d_e, r_e);
        n_checks++;
        if (k_ev !== 7 || sa !== 1'b1 || sp !== 2'd2) begin
            n_fail++;
            $display("FAIL speed_at_terminal: got latency=%0d step=%b speed=%0d expected 7 1 2", k_ev, sa, sp);
        end
        n_checks++;
        if (k_step - k_ev !== 10) begin
            n_fail++;
            $display("FAIL full_period_after_terminal: got %0d cycles expected 10", k_step - k_ev);
        end
    endtask

    task automatic test_reset_mid;
        int k_ev, k_step, n;
        logic sa, d_e, r_e;
        logic [1:0] sp;
        hold_keys(2'b10, k_ev, k_step, sa, sp, d_e, r_e);
        n_checks++;
        if (r_e !== 1'b0 || speed !== 2'd2) begin
            n_fail++;
            $display("FAIL pre_reset_state: got run=%b speed=%0d expected 0 2", r_e, speed);
        end
        for (int i = 0; i < 3; i++) tick;
        rst = 1'b1;
        tick;
        n_checks++;
        if ({step, dir, run, speed} !== 5'b00100) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got step=%b dir=%b run=%b speed=%0d expected 0 0 1 0", step, dir, run, speed);
        end
        rst = 1'b0;
        wait_step(100, n);
        n_checks++;
        if (n !== 40) begin
            n_fail++;
            $display("FAIL step_after_mid_reset: got %0d cycles expected 40", n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset;
        test_bounce;
        test_speed_cycle;
        test_mode;
        test_simultaneous;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
